// File: rtl/rs_decode_scheduler_if.sv
// Bus bundle for rs_decode_scheduler: two codeword requesters, the shared RS decoder
// link and the result port. slave = scheduler side, master = environment side.
interface rs_decode_scheduler_if #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int TAG_WIDTH    = 4
);
  localparam int CW_W = N * SYMBOL_WIDTH;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [CW_W-1:0]      req0_codeword;
  logic [TAG_WIDTH-1:0] req0_tag;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [CW_W-1:0]      req1_codeword;
  logic [TAG_WIDTH-1:0] req1_tag;

  logic                 dec_reset;
  logic [CW_W-1:0]      dec_codeword;
  logic [CW_W-1:0]      dec_corrected;

  logic                 res_valid;
  logic                 res_ready;
  logic [CW_W-1:0]      res_data;
  logic                 res_src;
  logic [TAG_WIDTH-1:0] res_tag;
  logic [2:0]           res_nerr;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_codeword, req0_tag,
    output req0_ready,
    input  req1_valid, req1_codeword, req1_tag,
    output req1_ready,
    output dec_reset, dec_codeword,
    input  dec_corrected,
    output res_valid, res_data, res_src, res_tag, res_nerr,
    input  res_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_codeword, req0_tag,
    input  req0_ready,
    output req1_valid, req1_codeword, req1_tag,
    input  req1_ready,
    input  dec_reset, dec_codeword,
    output dec_corrected,
    input  res_valid, res_data, res_src, res_tag, res_nerr,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/rs_decode_scheduler.sv
// Round-robin front end sharing one RS(7,5) decoder between two requesters.
// Optional RS_SCHED_STATS_EN adds saturating job/correction counters.
module rs_decode_scheduler #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int DEC_LATENCY  = 1,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rs_decode_scheduler_if.slave  bus
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_jobs0,
  output logic [15:0]           stat_jobs1,
  output logic [15:0]           stat_corrected
`endif
);
  localparam int CW_W  = N * SYMBOL_WIDTH;
  localparam int CNT_W = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;

  if (DEC_LATENCY < 1) begin : g_lat_chk
    $error("DEC_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 src_q, src_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CW_W-1:0]      data_q, data_d;
  logic [2:0]           nerr_q, nerr_d;

  logic                 ready0, ready1;
  logic [2:0]           nerr_calc;

  // Grant is a pure function of valids and the pointer; only offered in IDLE.
  always_comb begin
    ready0 = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid || !ptr_q);
    ready1 = (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  end

  always_comb begin
    nerr_calc = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.dec_corrected[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] != cw_q[i*SYMBOL_WIDTH +: SYMBOL_WIDTH])
        nerr_calc = nerr_calc + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cw_d    = cw_q;
    tag_d   = tag_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    nerr_d  = nerr_q;
    case (state_q)
      S_IDLE: begin
        if (ready0 || ready1) begin
          cw_d    = ready1 ? bus.req1_codeword : bus.req0_codeword;
          tag_d   = ready1 ? bus.req1_tag      : bus.req0_tag;
          src_d   = ready1;
          ptr_d   = !ready1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_W'(DEC_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = bus.dec_corrected;
          nerr_d  = nerr_calc;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_OUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      cw_q    <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      nerr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cw_q    <= cw_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      nerr_q  <= nerr_d;
    end
  end

  // Decoder only runs out of reset while we wait on it.
  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.dec_reset    = (state_q != S_WAIT);
  assign bus.dec_codeword = cw_q;
  assign bus.res_valid    = (state_q == S_OUT);
  assign bus.res_data     = data_q;
  assign bus.res_src      = src_q;
  assign bus.res_tag      = tag_q;
  assign bus.res_nerr     = nerr_q;
  assign bus.busy         = (state_q != S_IDLE);

`ifdef RS_SCHED_STATS_EN
  logic [15:0] jobs0_q, jobs0_d, jobs1_q, jobs1_d, corr_q, corr_d;

  always_comb begin
    jobs0_d = jobs0_q;
    jobs1_d = jobs1_q;
    corr_d  = corr_q;
    if (ready0 && jobs0_q != 16'hFFFF) jobs0_d = jobs0_q + 16'd1;
    if (ready1 && jobs1_q != 16'hFFFF) jobs1_d = jobs1_q + 16'd1;
    if (state_q == S_OUT && bus.res_ready && nerr_q != 3'd0 && corr_q != 16'hFFFF)
      corr_d = corr_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jobs0_q <= '0;
      jobs1_q <= '0;
      corr_q  <= '0;
    end else begin
      jobs0_q <= jobs0_d;
      jobs1_q <= jobs1_d;
      corr_q  <= corr_d;
    end
  end

  assign stat_jobs0     = jobs0_q;
  assign stat_jobs1     = jobs1_q;
  assign stat_corrected = corr_q;
`endif
endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Directed bench for rs_decode_scheduler: two instances (DEC_LATENCY 1 and 3), each with
// a stub decoder that only produces a corrected word after running long enough out of reset.
module tb_rs_decode_scheduler;
  localparam int SW = 3;
  localparam int N  = 7;
  localparam int TW = 4;
  localparam int CW = N * SW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int both_hi = 0;

  rs_decode_scheduler_if #(.SYMBOL_WIDTH(SW), .N(N), .TAG_WIDTH(TW)) bus ();
  rs_decode_scheduler_if #(.SYMBOL_WIDTH(SW), .N(N), .TAG_WIDTH(TW)) bus3 ();

`ifdef RS_SCHED_STATS_EN
  logic [15:0] sj0, sj1, sc, sj0b, sj1b, scb;
`endif

  rs_decode_scheduler #(.SYMBOL_WIDTH(SW), .N(N), .DEC_LATENCY(1), .TAG_WIDTH(TW)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef RS_SCHED_STATS_EN
    , .stat_jobs0(sj0), .stat_jobs1(sj1), .stat_corrected(sc)
`endif
  );

  rs_decode_scheduler #(.SYMBOL_WIDTH(SW), .N(N), .DEC_LATENCY(3), .TAG_WIDTH(TW)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
`ifdef RS_SCHED_STATS_EN
    , .stat_jobs0(sj0b), .stat_jobs1(sj1b), .stat_corrected(scb)
`endif
  );

  // Stub decoder: a few known-bad words map to 0x00E67C, everything else passes through.
  function automatic logic [CW-1:0] fix(input logic [CW-1:0] c);
    if (c == 21'h00E67D || c == 21'h10E67D || c == 21'h00E67B) return 21'h00E67C;
    return c;
  endfunction

  logic [3:0] rc, rc3;
  always @(posedge clk) rc  <= bus.dec_reset  ? 4'd0 : rc  + 4'd1;
  always @(posedge clk) rc3 <= bus3.dec_reset ? 4'd0 : rc3 + 4'd1;
  assign bus.dec_corrected  = (!bus.dec_reset)                    ? fix(bus.dec_codeword)  : '1;
  assign bus3.dec_corrected = (!bus3.dec_reset && rc3 >= 4'd2)    ? fix(bus3.dec_codeword) : '1;

  always @(negedge clk) if (bus.req0_ready && bus.req1_ready) both_hi++;

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tg, got, exp);
    end
  endtask

  task automatic do_job(input bit s, input logic [CW-1:0] cw, input logic [TW-1:0] tg,
                        input logic [CW-1:0] xd, input logic [2:0] xn);
    int w, lat;
    @(negedge clk);
    if (s) begin bus.req1_codeword = cw; bus.req1_tag = tg; bus.req1_valid = 1'b1; end
    else   begin bus.req0_codeword = cw; bus.req0_tag = tg; bus.req0_valid = 1'b1; end
    #1; w = 0;
    while (!(s ? bus.req1_ready : bus.req0_ready) && w < 20) begin @(negedge clk); #1; w++; end
    chk("grant", s ? bus.req1_ready : bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1; lat = 1;
    chk("load_busy", bus.busy, 1);
    while (!bus.res_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    chk("latency", lat, 3);
    chk("res_data", bus.res_data, xd);
    chk("res_src", bus.res_src, s);
    chk("res_tag", bus.res_tag, tg);
    chk("res_nerr", bus.res_nerr, xn);
    chk("out_dec_reset", bus.dec_reset, 1);
    @(negedge clk); #1;
    chk("idle_busy", bus.busy, 0);
    chk("res_drop", bus.res_valid, 0);
  endtask

  task automatic do_job3(input logic [CW-1:0] cw, input logic [TW-1:0] tg,
                         input logic [CW-1:0] xd, input logic [2:0] xn);
    int w, lat;
    @(negedge clk);
    bus3.req0_codeword = cw; bus3.req0_tag = tg; bus3.req0_valid = 1'b1;
    #1; w = 0;
    while (!bus3.req0_ready && w < 20) begin @(negedge clk); #1; w++; end
    chk("l3_grant", bus3.req0_ready, 1);
    @(negedge clk);
    bus3.req0_valid = 1'b0;
    #1; lat = 1;
    while (!bus3.res_valid && lat < 30) begin @(negedge clk); #1; lat++; end
    chk("l3_latency", lat, 5);
    chk("l3_res_data", bus3.res_data, xd);
    chk("l3_res_nerr", bus3.res_nerr, xn);
    chk("l3_res_tag", bus3.res_tag, tg);
    @(negedge clk); #1;
    chk("l3_idle", bus3.busy, 0);
  endtask

  initial begin
    int w, bad;
    logic [CW-1:0] hd;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_codeword = '0; bus.req1_codeword = '0;
    bus.req0_tag = '0; bus.req1_tag = '0; bus.res_ready = 1'b1;
    bus3.req0_valid = 0; bus3.req1_valid = 0; bus3.req0_codeword = '0; bus3.req1_codeword = '0;
    bus3.req0_tag = '0; bus3.req1_tag = '0; bus3.res_ready = 1'b1;

    // reset state
    #12;
    chk("rst_dec_reset", bus.dec_reset, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dec_cw", bus.dec_codeword, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_nerr", bus.res_nerr, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // clean, tamper, two-symbol, multi-bit-one-symbol
    do_job(1'b0, 21'h00E67C, 4'h3, 21'h00E67C, 3'd0);
    do_job(1'b1, 21'h00E67D, 4'h5, 21'h00E67C, 3'd1);
    do_job(1'b0, 21'h10E67D, 4'h9, 21'h00E67C, 3'd2);
    do_job(1'b1, 21'h00E67B, 4'hA, 21'h00E67C, 3'd1);

    // both requesters continuously valid
    @(negedge clk);
    bus.req0_codeword = 21'h00E67C; bus.req0_tag = 4'h1; bus.req0_valid = 1'b1;
    bus.req1_codeword = 21'h00E67D; bus.req1_tag = 4'h2; bus.req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(bus.req0_ready || bus.req1_ready) && w < 20) begin @(negedge clk); #1; w++; end
      chk("arb_grant", bus.req1_ready, k % 2);
      w = 0;
      while (!bus.res_valid && w < 20) begin @(negedge clk); #1; w++; end
      chk("arb_res_src", bus.res_src, k % 2);
      chk("arb_res_nerr", bus.res_nerr, k % 2);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("never_both_ready", both_hi, 0);
    repeat (2) @(negedge clk);

    // backpressure: result held, no accepts while OUT
    bus.res_ready = 1'b0;
    bus.req0_codeword = 21'h00E67D; bus.req0_tag = 4'h7; bus.req0_valid = 1'b1;
    @(negedge clk); bus.req0_valid = 1'b0; #1;
    w = 0;
    while (!bus.res_valid && w < 20) begin @(negedge clk); #1; w++; end
    chk("bp_valid", bus.res_valid, 1);
    hd = bus.res_data;
    chk("bp_data", hd, 21'h00E67C);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (bus.res_data !== 21'h00E67C || bus.res_tag !== 4'h7 || bus.res_nerr !== 3'd1 ||
          bus.res_src !== 1'b0 || !bus.res_valid || bus.req0_ready || bus.req1_ready ||
          !bus.dec_reset) bad++;
    end
    chk("bp_hold", bad, 0);
    bus.res_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release", bus.res_valid, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // reset during WAIT
    bus.req0_codeword = 21'h00E67C; bus.req0_tag = 4'h4; bus.req0_valid = 1'b1;
    @(negedge clk); bus.req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("mid_in_wait", bus.dec_reset, 0);
    reset = 1'b0; #1;
    chk("mid_dec_reset", bus.dec_reset, 1);
    chk("mid_res_valid", bus.res_valid, 0);
    chk("mid_busy", bus.busy, 0);
    @(negedge clk); reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); #1; if (bus.res_valid || bus.busy) bad++; end
    chk("mid_no_result", bad, 0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
    chk("mid_ptr0", bus.req0_ready, 1);
    chk("mid_ptr1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // DEC_LATENCY=3 instance
    do_job3(21'h00E67C, 4'h6, 21'h00E67C, 3'd0);
    do_job3(21'h00E67D, 4'h8, 21'h00E67C, 3'd1);
`ifdef RS_SCHED_STATS_EN
    chk("stat_jobs0", sj0b, 2);
    chk("stat_jobs1", sj1b, 0);
    chk("stat_corrected", scb, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rs_decode_scheduler.md
Name: rs_decode_scheduler

Overview:
Front-end controller that shares one RS(7,5) GF(8) RS_Decoder between two requester channels.
- Round-robin arbitration between the two requesters.
- Latches the winner's codeword and sequences the decoder's reset/evaluate protocol over a fixed number of cycles.
- Captures the corrected codeword and returns it with source id, tag and corrected-symbol count over a valid/ready result port.
- Sits between codeword producers and the RS_Decoder instance.

Parameters:
SYMBOL_WIDTH, 3, bits per GF(8) symbol
N, 7, symbols per codeword
DEC_LATENCY, 1, cycles decoder runs out of reset before corrected output is sampled; must be >=1, 0 is an elaboration error
TAG_WIDTH, 4, width of requester tag carried through to the result

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a codeword
req0_ready  out  1  scheduler accepts requester 0 this cycle
req0_codeword  in  N*SYMBOL_WIDTH  requester 0 codeword, MSB symbol first
req0_tag  in  TAG_WIDTH  requester 0 tag
req1_valid / req1_ready / req1_codeword / req1_tag  same as requester 0
dec_reset  out  1  active-high reset to RS_Decoder
dec_codeword  out  N*SYMBOL_WIDTH  codeword driven to RS_Decoder
dec_corrected  in  N*SYMBOL_WIDTH  RS_Decoder corrected output
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  N*SYMBOL_WIDTH  corrected codeword
res_src  out  1  0 = requester 0, 1 = requester 1
res_tag  out  TAG_WIDTH  tag of the originating request
res_nerr  out  3  count of symbol positions where res_data differs from the submitted codeword (0..7)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: state=IDLE, all outputs 0 except dec_reset=1; dec_codeword=0.
  - RR pointer favours requester 0.
  - Reset mid-operation abandons the job; no result is produced.
- States: IDLE, LOAD, WAIT, OUT.
- IDLE, arbitration:
  - grant = the valid requester if only one is valid.
  - If both are valid, grant = the RR pointer.
  - reqX_ready=1 only for the granted requester, combinationally from valid and pointer; the other ready is 0.
- IDLE, accept (on valid&&ready):
  - Latch codeword, tag and src.
  - RR pointer := other than the winner.
  - -> LOAD.
- IDLE, no valid: stay; dec_reset=1.
- LOAD (1 cycle): dec_codeword=latched codeword, dec_reset=1. -> WAIT, wait counter := DEC_LATENCY-1.
- WAIT:
  - dec_reset=0; dec_codeword held.
  - When counter==0: sample dec_corrected into res_data and compute res_nerr at this edge, -> OUT. Otherwise decrement.
- OUT:
  - res_valid=1; res_data/res_src/res_tag/res_nerr stable until handshake.
  - dec_reset=1; both ready=0.
  - On res_ready -> IDLE, res_valid=0 next cycle.
- Latency: result valid DEC_LATENCY+2 cycles after the accepting edge. With DEC_LATENCY=1, res_valid rises 3 cycles after accept.
- Throughput: at most one job per DEC_LATENCY+3 cycles; no accept while busy.
- Backpressure: a result held in OUT indefinitely blocks new accepts.
- res_nerr arithmetic: per-symbol compare of SYMBOL_WIDTH-bit fields, popcount of mismatches, 3 bits, no saturation needed (max 7).
- Requester protocol: requesters hold codeword/tag stable while valid&&!ready. The scheduler samples only at the accept edge.

Optional Feature:
RS_SCHED_STATS_EN
- Defined:
  - Adds outputs stat_jobs0, stat_jobs1 (16 bits each), incremented on each accept from that requester.
  - Adds stat_corrected (16 bits), incremented on each result handshake with res_nerr!=0.
  - All three saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Clean codeword, single requester, DEC_LATENCY=1:
  - Stimulus: req0_valid=1, codeword=21'h00E67C, tag=4'h3, res_ready=1.
  - Response: accept on first edge; res_valid 3 cycles later with res_data=21'h00E67C, res_src=0, res_tag=3, res_nerr=0; busy back to 0 after handshake.
- Single-bit tamper:
  - Stimulus: req1 codeword=21'h00E67D (bit 0 flipped).
  - Response: res_data=21'h00E67C, res_nerr=1, res_src=1.
- Both requesters continuously valid, 4 jobs:
  - Response: grant order 0,1,0,1; never two readies high in one cycle.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles after res_valid.
  - Response: res_* stable, req0_ready/req1_ready=0 throughout, dec_reset=1; the job completes when res_ready rises.
- Reset mid-job:
  - Stimulus: reset=0 during WAIT.
  - Response: immediately dec_reset=1, res_valid=0, busy=0; no result emitted after release; pointer back to requester 0.
- DEC_LATENCY=3 with RS_SCHED_STATS_EN:
  - Stimulus: one clean and one tampered job from req0.
  - Response: res_valid 5 cycles after each accept; stat_jobs0=2, stat_jobs1=0, stat_corrected=1.
